// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default bit timing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // 115200 baud from a 100 MHz clock; the transmitter uses the same value.
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is always visible
// on rd_data. A push into a full FIFO is taken only when a pop frees a slot
// in the same cycle. A pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage, pointers (wrap modulo DEPTH) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small FWFT FIFO.
// Consumer handshake: a byte is taken from rx_data on any rising clk edge where
// rx_valid=1 and rx_ready=1. rx_valid never depends on rx_ready, and rx_data
// stays stable while rx_valid=1 and no pop occurs.
// The FSM state is exported on 'state' for observation.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DEPTH        = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   frame_err,
  output logic                   overrun,
  input  logic                   overrun_clr,
  output logic [$clog2(DEPTH):0] fifo_count,
  output rx_state_e              state
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  logic        rx_s1, rx_s2, rx_prev;
  logic        fall;
  rx_state_e   state_q, state_d;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_q;
  logic        baud_clr, bit_clr, shift_en, push_req, ferr_d;
  logic        fifo_full, fifo_empty, pop_req, overrun_evt;

  assign fall  = rx_prev & ~rx_s2;
  assign state = state_q;

  // Two-flop synchronizer plus a history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath control; sampling points are mid-bit.
  always_comb begin
    state_d  = state_q;
    baud_clr = 1'b0;
    bit_clr  = 1'b0;
    shift_en = 1'b0;
    push_req = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d  = START;
          baud_clr = 1'b1;
        end
      end
      START: begin
        if (baud_cnt == HALF_LAST) begin
          baud_clr = 1'b1;
          if (!rx_s2) begin
            state_d = DATA;
            bit_clr = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_clr = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_clr = 1'b1;
          state_d  = IDLE;
          push_req = rx_s2;
          ferr_d   = ~rx_s2;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Baud/bit counters, shift register, frame error pulse and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (baud_clr || state_q == IDLE) baud_cnt <= '0;
      else                              baud_cnt <= baud_cnt + 16'd1;
      if (bit_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shift_q[bit_cnt] <= rx_s2;
      frame_err <= ferr_d;
      // An overrun event wins over a simultaneous clear.
      if (overrun_evt)      overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  assign rx_valid    = ~fifo_empty;
  assign pop_req     = rx_valid & rx_ready;
  assign overrun_evt = push_req & fifo_full & ~pop_req;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_req),
    .pop     (pop_req),
    .wr_data (shift_q),
    .rd_data (rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule
